// File: rtl/id_stage.sv
// Decode stage of the 5-stage in-order LoongArch pipeline: stage register, register file,
// integer-subset decode, RAW interlock and in-ID branch resolution.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h1bff_fffc
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         if_to_id_valid,
    input  logic [63:0]  if_to_id_bus,
    output logic         id_allowin,
    output logic [33:0]  id_to_if_bus,
    input  logic         exe_allowin,
    output logic         id_to_exe_valid,
    output logic [139:0] id_to_exe_bus,
    input  logic [5:0]   exe_dest,
    input  logic [5:0]   mem_dest,
    input  logic         wb_rf_we,
    input  logic [4:0]   wb_rf_waddr,
    input  logic [31:0]  wb_rf_wdata
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_rf [32];

    logic [4:0]  w_rj, w_rk, w_rd, w_dest;
    logic [31:0] w_rj_val, w_rk_val, w_rd_val;
    logic        w_add, w_sub, w_slt, w_sltu, w_nor, w_and, w_or, w_xor, w_3r;
    logic        w_addi, w_ld, w_st, w_lu12i, w_jirl, w_b, w_bl, w_beq, w_bne;
    logic        w_use_rj, w_use_rk, w_use_rd, w_ready_go, w_eq, w_br_taken;
    logic        w_gr_we;
    logic [3:0]  w_alu_op;
    logic [31:0] w_src1, w_src2, w_br_target;
    logic [31:0] w_si12, w_offs16, w_offs26;

    function automatic logic hit(input logic [4:0] a, input logic [5:0] d);
        return (a != 5'd0) && d[5] && (d[4:0] == a);
    endfunction

    assign w_rj = r_inst[9:5];
    assign w_rk = r_inst[14:10];
    assign w_rd = r_inst[4:0];

    // Same-cycle writeback is bypassed so a stalled reader sees the value being committed.
    assign w_rj_val = (w_rj == 5'd0) ? 32'd0 :
                      (wb_rf_we && wb_rf_waddr == w_rj) ? wb_rf_wdata : r_rf[w_rj];
    assign w_rk_val = (w_rk == 5'd0) ? 32'd0 :
                      (wb_rf_we && wb_rf_waddr == w_rk) ? wb_rf_wdata : r_rf[w_rk];
    assign w_rd_val = (w_rd == 5'd0) ? 32'd0 :
                      (wb_rf_we && wb_rf_waddr == w_rd) ? wb_rf_wdata : r_rf[w_rd];

    always_ff @(posedge clk) begin
        if (wb_rf_we && wb_rf_waddr != 5'd0) begin
            r_rf[wb_rf_waddr] <= wb_rf_wdata;
        end
    end

    assign w_add   = r_inst[31:15] == 17'h00020;
    assign w_sub   = r_inst[31:15] == 17'h00022;
    assign w_slt   = r_inst[31:15] == 17'h00024;
    assign w_sltu  = r_inst[31:15] == 17'h00025;
    assign w_nor   = r_inst[31:15] == 17'h00028;
    assign w_and   = r_inst[31:15] == 17'h00029;
    assign w_or    = r_inst[31:15] == 17'h0002a;
    assign w_xor   = r_inst[31:15] == 17'h0002b;
    assign w_3r    = w_add | w_sub | w_slt | w_sltu | w_nor | w_and | w_or | w_xor;
    assign w_addi  = r_inst[31:22] == 10'h00a;
    assign w_ld    = r_inst[31:22] == 10'h0a2;
    assign w_st    = r_inst[31:22] == 10'h0a6;
    assign w_lu12i = r_inst[31:25] == 7'h0a;
    assign w_jirl  = r_inst[31:26] == 6'h13;
    assign w_b     = r_inst[31:26] == 6'h14;
    assign w_bl    = r_inst[31:26] == 6'h15;
    assign w_beq   = r_inst[31:26] == 6'h16;
    assign w_bne   = r_inst[31:26] == 6'h17;

    assign w_si12   = {{20{r_inst[21]}}, r_inst[21:10]};
    assign w_offs16 = {{14{r_inst[25]}}, r_inst[25:10], 2'b00};
    assign w_offs26 = {{4{r_inst[9]}}, r_inst[9:0], r_inst[25:10], 2'b00};

    assign w_use_rj = w_3r | w_addi | w_ld | w_st | w_jirl | w_beq | w_bne;
    assign w_use_rk = w_3r;
    assign w_use_rd = w_st | w_beq | w_bne;

    assign w_ready_go = ~((w_use_rj && (hit(w_rj, exe_dest) || hit(w_rj, mem_dest))) ||
                          (w_use_rk && (hit(w_rk, exe_dest) || hit(w_rk, mem_dest))) ||
                          (w_use_rd && (hit(w_rd, exe_dest) || hit(w_rd, mem_dest))));

    always_comb begin
        w_alu_op = 4'd0;
        if (w_sub)   w_alu_op = 4'd1;
        if (w_slt)   w_alu_op = 4'd2;
        if (w_sltu)  w_alu_op = 4'd3;
        if (w_and)   w_alu_op = 4'd4;
        if (w_or)    w_alu_op = 4'd5;
        if (w_xor)   w_alu_op = 4'd6;
        if (w_nor)   w_alu_op = 4'd7;
        if (w_lu12i) w_alu_op = 4'd8;
    end

    always_comb begin
        w_src2 = 32'd0;
        if (w_3r)                      w_src2 = w_rk_val;
        else if (w_addi | w_ld | w_st) w_src2 = w_si12;
        else if (w_lu12i)              w_src2 = {r_inst[24:5], 12'b0};
        else if (w_jirl | w_bl)        w_src2 = 32'd4;
    end

    assign w_src1  = (w_jirl | w_bl) ? r_pc : w_rj_val;
    assign w_dest  = w_bl ? 5'd1 : w_rd;
    assign w_gr_we = (w_3r | w_addi | w_ld | w_lu12i | w_jirl | w_bl) & (w_dest != 5'd0);

    assign w_eq        = w_rj_val == w_rd_val;
    assign w_br_target = w_jirl ? (w_rj_val + w_offs16) :
                         (w_b | w_bl) ? (r_pc + w_offs26) : (r_pc + w_offs16);
    assign w_br_taken  = r_valid & w_ready_go & exe_allowin &
                         (w_b | w_bl | w_jirl | (w_beq & w_eq) | (w_bne & ~w_eq));

    assign id_allowin      = ~r_valid | (w_ready_go & exe_allowin);
    assign id_to_exe_valid = r_valid & w_ready_go;
    assign id_to_if_bus    = {w_br_taken, w_br_target, w_br_taken};
    assign id_to_exe_bus   = {w_alu_op, w_src1, w_src2, w_rd_val, w_st, w_ld, w_gr_we,
                              w_dest, r_pc};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_inst  <= 32'd0;
        end else if (id_allowin) begin
            r_valid <= if_to_id_valid & ~w_br_taken;
            if (if_to_id_valid) begin
                r_pc   <= if_to_id_bus[63:32];
                r_inst <= if_to_id_bus[31:0];
            end
        end
    end

endmodule
